seletor_registo_r: RTL and testbench
====================================

Name: seletor_registo_r

Overview:
Parametrised successor to the register-R source multiplexer. Selects one of NUM_SRC data sources (constant, memory data, external input, ALU result, spare) and captures it into an internal register R, which drives the datapath. It adds a load handshake, a wait state for the external input source with a timeout, and an out-of-range select error. It sits between the datapath sources and the accumulator/register R input of the processor.

Parameters:
WIDTH, 8, data width of every source and of R
NUM_SRC, 5, number of selectable sources; index 0 constant, 1 memory, 2 external input, 3 result, 4 spare
SEL_W, 3, width of sel; must satisfy 2**SEL_W >= NUM_SRC
IN_IDX, 2, source index requiring the in_valid/in_ready handshake
TIMEOUT, 16, cycles to wait for in_valid before aborting; 1..2**16-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
src_data  in  NUM_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]
sel  in  SEL_W  source index, sampled only when load_req is accepted
load_req  in  1  request to load R; accepted only when busy=0
in_valid  in  1  external input data valid (source IN_IDX)
in_ready  out  1  block is waiting for external input
dados_r  out  WIDTH  current contents of R
load_done  out  1  one-cycle pulse: R was updated on this edge
busy  out  1  request in progress (state WAIT_IN)
sel_err  out  1  one-cycle pulse: sel >= NUM_SRC at acceptance
timeout_err  out  1  one-cycle pulse: WAIT_IN expired without in_valid

Behaviour:
- Reset (async, rst_n=0): R=0; load_done, sel_err, timeout_err, in_ready and busy are 0; state is IDLE; the timeout counter is 0. Release is synchronous to clk.
- States: IDLE, WAIT_IN.
- IDLE, load_req=0: hold R. All pulse outputs are 0.
- IDLE, load_req=1, sel >= NUM_SRC: R unchanged; sel_err=1 for exactly the next cycle; stay IDLE.
- IDLE, load_req=1, sel < NUM_SRC, sel != IN_IDX: at the next edge, R <= source[sel] and load_done=1 for one cycle. Latency is 1 cycle. Back-to-back requests are accepted every cycle.
- IDLE, load_req=1, sel == IN_IDX, in_valid=1: same-cycle capture. At the next edge, R <= source[IN_IDX] and load_done pulses.
- IDLE, load_req=1, sel == IN_IDX, in_valid=0: go to WAIT_IN. Latch the selected index and load TIMEOUT-1 into the counter.
- WAIT_IN: in_ready=1 and busy=1. load_req is ignored: no queueing and no error.
  - in_valid=1: R <= source[IN_IDX] and load_done pulses. Return to IDLE. in_ready drops in the following cycle.
  - in_valid=0 and counter==0: R unchanged; timeout_err pulses for one cycle; return to IDLE.
  - Otherwise, decrement the counter.
  - in_valid and expiry in the same cycle: the data wins. Load, with no timeout_err.
- in_valid outside WAIT_IN, with no matching request, is ignored.
- At most one of load_done, sel_err and timeout_err is high in any cycle.
- All outputs are registered. dados_r changes only on the edge that also asserts load_done.
- Reset asserted mid-WAIT_IN: immediate return to the reset values. The pending request is discarded.

Decomposition:
- Shared include file (project defines) holds:
  - source index constants SRC_CONST=0, SRC_MEM=1, SRC_IN=2, SRC_RES=3;
  - state encodings IDLE=1'b0, WAIT_IN=1'b1.
- One natural sub-module, contador_timeout: a loadable down-counter with a load, an enable, and a zero flag. Its width is clog2(TIMEOUT).
- Source extraction is an indexed part-select inside the top level. It needs no separate module.

Test Plan:
- Reset: rst_n=0 asynchronously, mid-cycle, with R=0x5A. dados_r must read 0x00 immediately, with all flags 0.
- Direct load: src_data source 3 = 0xC3, sel=3, load_req for 1 cycle. dados_r=0xC3 and load_done=1 exactly one cycle later. A back-to-back request with sel=0 (0x11) must give 0x11 on the next cycle.
- External wait: sel=2, in_valid=0 for 5 cycles, then in_valid=1 with source 2 = 0x7E. in_ready and busy must be high for 5 cycles, then dados_r=0x7E with a load_done pulse.
- Timeout: TIMEOUT=4, sel=2, in_valid held at 0. Expect a timeout_err pulse 4 cycles after acceptance, R unchanged, and a return to IDLE. Also in_valid=1 in the expiry cycle must load, with no timeout_err.
- Bad select: NUM_SRC=5, sel=6. Expect a sel_err pulse and R unchanged. A load_req issued during WAIT_IN must be ignored.
- Reset during WAIT_IN: assert rst_n=0 in cycle 2 of the wait. in_ready=0 and R=0 at once. A subsequent in_valid must cause no load.

Source files
------------

// File: rtl/seletor_registo_r_pkg.sv
// rtl/seletor_registo_r_pkg.sv - shared source indices, state encoding and counter sizing
package seletor_registo_r_pkg;

  localparam int SRC_CONST = 0;
  localparam int SRC_MEM   = 1;
  localparam int SRC_IN    = 2;
  localparam int SRC_RES   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_IN = 1'b1
  } state_e;

  // A single-cycle timeout still needs one counter bit.
  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/seletor_registo_r_contador_timeout.sv
// rtl/seletor_registo_r_contador_timeout.sv - loadable down-counter with zero flag for the WAIT_IN timeout
module contador_timeout
  import seletor_registo_r_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seletor_registo_r.sv
// rtl/seletor_registo_r.sv - register R source selector with external-input handshake,
// timeout and out-of-range select error
module seletor_registo_r
  import seletor_registo_r_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3,
  parameter int IN_IDX  = SRC_IN,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     load_req,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         dados_r,
  output logic                     load_done,
  output logic                     busy,
  output logic                     sel_err,
  output logic                     timeout_err
);

  localparam int               CW        = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   NUM_SRC_V = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] IN_IDX_V  = SEL_W'(IN_IDX);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             load_done_q, load_done_d;
  logic             sel_err_q, sel_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_data;

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_contador_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // While waiting, the latched index drives the mux so sel may change freely.
  assign mux_idx = (state_q == WAIT_IN) ? sel_q : sel;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (mux_idx == SEL_W'(k)) begin
        mux_data = src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    sel_d         = sel_q;
    load_done_d   = 1'b0;
    sel_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          if ({1'b0, sel} >= NUM_SRC_V) begin
            sel_err_d = 1'b1;
          end else if ((sel != IN_IDX_V) || in_valid) begin
            r_d         = mux_data;
            load_done_d = 1'b1;
          end else begin
            state_d  = WAIT_IN;
            sel_d    = sel;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT_IN: begin
        // Data arriving in the expiry cycle takes priority over the timeout.
        if (in_valid) begin
          r_d         = mux_data;
          load_done_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_zero) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      r_q           <= '0;
      sel_q         <= '0;
      load_done_q   <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      sel_q         <= sel_d;
      load_done_q   <= load_done_d;
      sel_err_q     <= sel_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready    = (state_q == WAIT_IN);
  assign busy        = (state_q == WAIT_IN);
  assign dados_r     = r_q;
  assign load_done   = load_done_q;
  assign sel_err     = sel_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_seletor_registo_r.sv
// tb/tb_seletor_registo_r.sv - directed self-checking bench for seletor_registo_r
module tb_seletor_registo_r;

  logic        clk;
  logic        rst_n;
  logic [39:0] src_data;
  logic [2:0]  sel;
  logic        load_req;
  logic        in_valid;

  logic       d_in_ready, d_load_done, d_busy, d_sel_err, d_timeout_err;
  logic [7:0] d_dados_r;
  logic       t_in_ready, t_load_done, t_busy, t_sel_err, t_timeout_err;
  logic [7:0] t_dados_r;

  int total;
  int bad;

  seletor_registo_r dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel),
    .load_req(load_req), .in_valid(in_valid), .in_ready(d_in_ready),
    .dados_r(d_dados_r), .load_done(d_load_done), .busy(d_busy),
    .sel_err(d_sel_err), .timeout_err(d_timeout_err)
  );

  seletor_registo_r #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel),
    .load_req(load_req), .in_valid(in_valid), .in_ready(t_in_ready),
    .dados_r(t_dados_r), .load_done(t_load_done), .busy(t_busy),
    .sel_err(t_sel_err), .timeout_err(t_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [7:0] v);
    src_data[k*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    sel      = 3'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({d_dados_r, d_load_done, d_sel_err, d_timeout_err, d_in_ready, d_busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_init got %h exp 0", {d_dados_r, d_load_done, d_sel_err, d_timeout_err, d_in_ready, d_busy});
    end
    set_src(1, 8'h5A);
    sel = 3'd1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    total++;
    if (d_dados_r !== 8'h5A) begin bad++; $display("FAIL reset_preload got %h exp 5a", d_dados_r); end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({d_dados_r, d_load_done, d_sel_err, d_timeout_err, d_in_ready, d_busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_async got %h exp 0", {d_dados_r, d_load_done, d_sel_err, d_timeout_err, d_in_ready, d_busy});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_direct_load();
    do_reset();
    set_src(3, 8'hC3);
    set_src(0, 8'h11);
    sel = 3'd3; load_req = 1'b1;
    tick();
    total++;
    if ({d_dados_r, d_load_done} !== {8'hC3, 1'b1}) begin
      bad++; $display("FAIL direct_c3 got %h/%b exp c3/1", d_dados_r, d_load_done);
    end
    sel = 3'd0;
    tick();
    total++;
    if ({d_dados_r, d_load_done} !== {8'h11, 1'b1}) begin
      bad++; $display("FAIL b2b_11 got %h/%b exp 11/1", d_dados_r, d_load_done);
    end
    load_req = 1'b0;
    tick();
    total++;
    if ({d_dados_r, d_load_done} !== {8'h11, 1'b0}) begin
      bad++; $display("FAIL direct_hold got %h/%b exp 11/0", d_dados_r, d_load_done);
    end
  endtask

  task automatic test_external_wait();
    do_reset();
    set_src(2, 8'h7E);
    sel = 3'd2; load_req = 1'b1; in_valid = 1'b0;
    tick();
    load_req = 1'b0;
    sel = 3'd3;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({d_in_ready, d_busy, d_load_done, d_dados_r} !== {3'b110, 8'h00}) begin
        bad++; $display("FAIL wait_cycle%0d got %b%b%b/%h exp 110/00", i, d_in_ready, d_busy, d_load_done, d_dados_r);
      end
      if (i < 4) tick();
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({d_dados_r, d_load_done, d_in_ready, d_busy} !== {8'h7E, 3'b100}) begin
      bad++; $display("FAIL wait_load got %h/%b%b%b exp 7e/100", d_dados_r, d_load_done, d_in_ready, d_busy);
    end
    tick();
    total++;
    if ({d_load_done, d_in_ready} !== 2'b00) begin
      bad++; $display("FAIL wait_after got %b%b exp 00", d_load_done, d_in_ready);
    end
    // in_valid with no pending request must be ignored
    set_src(2, 8'h99);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({d_dados_r, d_load_done} !== {8'h7E, 1'b0}) begin
      bad++; $display("FAIL stray_valid got %h/%b exp 7e/0", d_dados_r, d_load_done);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_src(3, 8'h3C);
    sel = 3'd3; load_req = 1'b1;
    tick();
    sel = 3'd2; in_valid = 1'b0;
    tick();
    load_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if ({t_timeout_err, t_busy} !== 2'b01) begin
        bad++; $display("FAIL to_wait%0d got %b%b exp 01", i, t_timeout_err, t_busy);
      end
    end
    tick();
    total++;
    if ({t_timeout_err, t_busy, t_in_ready, t_load_done, t_dados_r} !== {4'b1000, 8'h3C}) begin
      bad++; $display("FAIL to_pulse got %b%b%b%b/%h exp 1000/3c", t_timeout_err, t_busy, t_in_ready, t_load_done, t_dados_r);
    end
    tick();
    total++;
    if (t_timeout_err !== 1'b0) begin bad++; $display("FAIL to_one_cycle got %b exp 0", t_timeout_err); end
    set_src(2, 8'hA5);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({t_dados_r, t_load_done, t_timeout_err, t_busy} !== {8'hA5, 3'b100}) begin
      bad++; $display("FAIL to_expiry_data got %h/%b%b%b exp a5/100", t_dados_r, t_load_done, t_timeout_err, t_busy);
    end
  endtask

  task automatic test_bad_select();
    do_reset();
    set_src(4, 8'h44);
    sel = 3'd4; load_req = 1'b1;
    tick();
    total++;
    if ({d_dados_r, d_load_done} !== {8'h44, 1'b1}) begin
      bad++; $display("FAIL sel4_ok got %h/%b exp 44/1", d_dados_r, d_load_done);
    end
    sel = 3'd6;
    tick();
    load_req = 1'b0;
    total++;
    if ({d_sel_err, d_load_done, d_dados_r} !== {2'b10, 8'h44}) begin
      bad++; $display("FAIL sel6_err got %b%b/%h exp 10/44", d_sel_err, d_load_done, d_dados_r);
    end
    sel = 3'd5; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    total++;
    if ({d_sel_err, d_busy, d_dados_r} !== {2'b10, 8'h44}) begin
      bad++; $display("FAIL sel5_err got %b%b/%h exp 10/44", d_sel_err, d_busy, d_dados_r);
    end
    tick();
    total++;
    if (d_sel_err !== 1'b0) begin bad++; $display("FAIL sel_err_pulse got %b exp 0", d_sel_err); end
    set_src(3, 8'hEE);
    set_src(2, 8'h2D);
    sel = 3'd2; load_req = 1'b1;
    tick();
    sel = 3'd3;
    tick();
    sel = 3'd6;
    tick();
    total++;
    if ({d_busy, d_load_done, d_sel_err, d_dados_r} !== {3'b100, 8'h44}) begin
      bad++; $display("FAIL wait_ignores_req got %b%b%b/%h exp 100/44", d_busy, d_load_done, d_sel_err, d_dados_r);
    end
    load_req = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({d_dados_r, d_load_done, d_busy} !== {8'h2D, 2'b10}) begin
      bad++; $display("FAIL wait_ignores_load got %h/%b%b exp 2d/10", d_dados_r, d_load_done, d_busy);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    set_src(3, 8'h81);
    set_src(2, 8'h42);
    sel = 3'd3; load_req = 1'b1;
    tick();
    sel = 3'd2;
    tick();
    load_req = 1'b0;
    tick();
    total++;
    if ({d_busy, d_dados_r} !== {1'b1, 8'h81}) begin
      bad++; $display("FAIL rw_prewait got %b/%h exp 1/81", d_busy, d_dados_r);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({d_in_ready, d_busy, d_dados_r} !== 10'h0) begin
      bad++; $display("FAIL rw_async got %b%b/%h exp 00/00", d_in_ready, d_busy, d_dados_r);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({d_load_done, d_busy, d_dados_r} !== 10'h0) begin
      bad++; $display("FAIL rw_no_load got %b%b/%h exp 00/00", d_load_done, d_busy, d_dados_r);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    src_data = '0;
    sel      = 3'd0;
    load_req = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_direct_load();
    test_external_wait();
    test_timeout();
    test_bad_select();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
